// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline control signals between the hazard controller and the CPU top.
// The slave modport is the controller side; the master modport is the CPU/datapath side.
interface pipeline_hazard_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
);
    logic            imem_ready;
    logic            dmem_req;
    logic            dmem_ready;
    logic [RA_W-1:0] id_rs1_addr;
    logic            id_rs1_used;
    logic [RA_W-1:0] id_rs2_addr;
    logic            id_rs2_used;
    logic [RA_W-1:0] ex_rs1_addr;
    logic [RA_W-1:0] ex_rs2_addr;
    logic [RA_W-1:0] ex_rd_addr;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic [RA_W-1:0] mem_rd_addr;
    logic            mem_reg_write;
    logic [RA_W-1:0] wb_rd_addr;
    logic            wb_reg_write;
    logic            ex_redirect;
    logic [XLEN-1:0] ex_target;

    logic [XLEN-1:0]  pc;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             valid_id;
    logic             valid_ex;
    logic             valid_mem;
    logic             valid_wb;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  imem_ready, dmem_req, dmem_ready,
        input  id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
        input  ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_reg_write, ex_mem_read,
        input  mem_rd_addr, mem_reg_write, wb_rd_addr, wb_reg_write,
        input  ex_redirect, ex_target,
        output pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
        output valid_id, valid_ex, valid_mem, valid_wb, fwd_a, fwd_b,
        output cycle_cnt, stall_cnt, flush_cnt
    );

    modport master (
        output imem_ready, dmem_req, dmem_ready,
        output id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
        output ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_reg_write, ex_mem_read,
        output mem_rd_addr, mem_reg_write, wb_rd_addr, wb_reg_write,
        output ex_redirect, ex_target,
        input  pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
        input  valid_id, valid_ex, valid_mem, valid_wb, fwd_a, fwd_b,
        input  cycle_cnt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// PC, stage-valid and hazard controller for a 5-stage pipeline: load-use interlock,
// forwarding selects, EX redirect with flush, imem/dmem wait states and perf counters.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_BOOT   | first cycle after reset release, nothing fetched, all enables low
// ST_RUN    | normal issue; redirect / load-use / imem wait handled here
// ST_DSTALL | MEM-stage data access outstanding, whole pipeline frozen
module pipeline_hazard_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              RA_W     = 5,
    parameter int              CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DSTALL = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             valid_id_q, valid_ex_q, valid_mem_q, valid_wb_q;
    logic             valid_id_d, valid_ex_d, valid_mem_d, valid_wb_d;
    logic [CNT_W-1:0] cycle_cnt_q, stall_cnt_q, flush_cnt_q;
    logic             cycle_inc, stall_inc, flush_inc;
    logic             ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
    logic             dmem_wait, redirect, load_use;
    logic [1:0]       fwd_a, fwd_b;

    assign dmem_wait = valid_mem_q & bus.dmem_req & ~bus.dmem_ready;
    assign redirect  = valid_ex_q & bus.ex_redirect;
    assign load_use  = valid_ex_q & bus.ex_mem_read & (bus.ex_rd_addr != '0) & valid_id_q &
                       ((bus.id_rs1_used & (bus.id_rs1_addr == bus.ex_rd_addr)) |
                        (bus.id_rs2_used & (bus.id_rs2_addr == bus.ex_rd_addr)));

    // State, PC, stage valids and perf counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            valid_id_q  <= 1'b0;
            valid_ex_q  <= 1'b0;
            valid_mem_q <= 1'b0;
            valid_wb_q  <= 1'b0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            valid_id_q  <= valid_id_d;
            valid_ex_q  <= valid_ex_d;
            valid_mem_q <= valid_mem_d;
            valid_wb_q  <= valid_wb_d;
            cycle_cnt_q <= cycle_cnt_q + {{(CNT_W-1){1'b0}}, cycle_inc};
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, stall_inc};
            flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, flush_inc};
        end
    end

    // Next state, PC and stage strobes by priority: dmem wait > redirect > load-use > imem wait > normal.
    // The cycle in which a data access completes advances like RUN, so each wait cycle costs exactly one.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        cycle_inc  = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN, ST_DSTALL: begin
                cycle_inc = 1'b1;
                if (dmem_wait) begin
                    state_d   = ST_DSTALL;
                    stall_inc = 1'b1;
                end else begin
                    state_d  = ST_RUN;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                    if (redirect) begin
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        pc_d       = bus.ex_target;
                        flush_inc  = 1'b1;
                    end else if (load_use) begin
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end else if (!bus.imem_ready) begin
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end else begin
                        ifid_en = 1'b1;
                        pc_d    = pc_q + XLEN'(4);
                    end
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // Valid bits follow the stage enables; a flush forces a bubble regardless of enable.
    always_comb begin
        valid_id_d  = ifid_flush ? 1'b0 : (ifid_en ? 1'b1 : valid_id_q);
        valid_ex_d  = idex_flush ? 1'b0 : (idex_en ? valid_id_q : valid_ex_q);
        valid_mem_d = exmem_en ? valid_ex_q : valid_mem_q;
        valid_wb_d  = memwb_en ? valid_mem_q : valid_wb_q;
    end

    // Operand forwarding selects; the younger MEM result beats WB.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (valid_mem_q && bus.mem_reg_write && bus.mem_rd_addr != '0 && bus.mem_rd_addr == bus.ex_rs1_addr)
            fwd_a = 2'b01;
        else if (valid_wb_q && bus.wb_reg_write && bus.wb_rd_addr != '0 && bus.wb_rd_addr == bus.ex_rs1_addr)
            fwd_a = 2'b10;
        if (valid_mem_q && bus.mem_reg_write && bus.mem_rd_addr != '0 && bus.mem_rd_addr == bus.ex_rs2_addr)
            fwd_b = 2'b01;
        else if (valid_wb_q && bus.wb_reg_write && bus.wb_rd_addr != '0 && bus.wb_rd_addr == bus.ex_rs2_addr)
            fwd_b = 2'b10;
    end

    assign bus.pc         = pc_q;
    assign bus.ifid_en    = ifid_en;
    assign bus.idex_en    = idex_en;
    assign bus.exmem_en   = exmem_en;
    assign bus.memwb_en   = memwb_en;
    assign bus.ifid_flush = ifid_flush;
    assign bus.idex_flush = idex_flush;
    assign bus.valid_id   = valid_id_q;
    assign bus.valid_ex   = valid_ex_q;
    assign bus.valid_mem  = valid_mem_q;
    assign bus.valid_wb   = valid_wb_q;
    assign bus.fwd_a      = fwd_a;
    assign bus.fwd_b      = fwd_b;
    assign bus.cycle_cnt  = cycle_cnt_q;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and random checks of pipeline_hazard_ctrl against a stage-occupancy reference model.
module tb_pipeline_hazard_ctrl;
    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    pipeline_hazard_ctrl_if #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(.XLEN(XLEN), .RESET_PC('0), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // reference model: which stages hold real instructions, fetch PC, counters
    logic        m_boot;
    logic [31:0] m_pc;
    logic        m_vid, m_vex, m_vmem, m_vwb;
    logic [31:0] m_cyc, m_stl, m_fl;

    logic [31:0] held_pc;
    logic [3:0]  held_v;
    logic [31:0] s0, f0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1;
        m_pc   = '0;
        m_vid  = 1'b0; m_vex = 1'b0; m_vmem = 1'b0; m_vwb = 1'b0;
        m_cyc  = '0;   m_stl = '0;   m_fl   = '0;
    endtask

    task automatic set_idle();
        bus.imem_ready = 1'b1; bus.dmem_req = 1'b0; bus.dmem_ready = 1'b1;
        bus.id_rs1_addr = '0; bus.id_rs1_used = 1'b0; bus.id_rs2_addr = '0; bus.id_rs2_used = 1'b0;
        bus.ex_rs1_addr = '0; bus.ex_rs2_addr = '0; bus.ex_rd_addr = '0;
        bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0;
        bus.mem_rd_addr = '0; bus.mem_reg_write = 1'b0;
        bus.wb_rd_addr = '0; bus.wb_reg_write = 1'b0;
        bus.ex_redirect = 1'b0; bus.ex_target = '0;
    endtask

    function automatic logic [1:0] exp_fwd(input logic [RA_W-1:0] rs);
        if (m_vmem && bus.mem_reg_write && bus.mem_rd_addr != 0 && bus.mem_rd_addr == rs) return 2'b01;
        if (m_vwb && bus.wb_reg_write && bus.wb_rd_addr != 0 && bus.wb_rd_addr == rs) return 2'b10;
        return 2'b00;
    endfunction

    // one clock: check outputs against the model at negedge, then let the model advance
    task automatic cyc();
        logic [3:0]  e_en;
        logic [1:0]  e_fl;
        logic [31:0] n_pc, n_cyc, n_stl, n_fl;
        logic        n_id, n_ex, n_mem, n_wb;
        logic        wait_d, redir, lu;
        @(negedge clk);
        e_en = 4'b0000; e_fl = 2'b00;
        n_pc = m_pc; n_id = m_vid; n_ex = m_vex; n_mem = m_vmem; n_wb = m_vwb;
        n_cyc = m_cyc; n_stl = m_stl; n_fl = m_fl;
        if (!m_boot) begin
            n_cyc  = m_cyc + 1;
            wait_d = m_vmem & bus.dmem_req & ~bus.dmem_ready;
            redir  = m_vex & bus.ex_redirect;
            lu     = m_vex & bus.ex_mem_read & (bus.ex_rd_addr != 0) & m_vid &
                     ((bus.id_rs1_used & (bus.id_rs1_addr == bus.ex_rd_addr)) |
                      (bus.id_rs2_used & (bus.id_rs2_addr == bus.ex_rd_addr)));
            if (wait_d) begin
                n_stl = m_stl + 1;
            end else if (redir) begin
                e_en = 4'b1111; e_fl = 2'b11;
                n_pc = bus.ex_target;
                n_id = 1'b0; n_ex = 1'b0; n_mem = m_vex; n_wb = m_vmem;
                n_fl = m_fl + 1;
            end else if (lu) begin
                e_en = 4'b0111; e_fl = 2'b01;
                n_ex = 1'b0; n_mem = m_vex; n_wb = m_vmem;
                n_stl = m_stl + 1;
            end else if (!bus.imem_ready) begin
                e_en = 4'b1111; e_fl = 2'b10;
                n_id = 1'b0; n_ex = m_vid; n_mem = m_vex; n_wb = m_vmem;
                n_stl = m_stl + 1;
            end else begin
                e_en = 4'b1111;
                n_pc = m_pc + 4;
                n_id = 1'b1; n_ex = m_vid; n_mem = m_vex; n_wb = m_vmem;
            end
        end
        chk("pc", bus.pc, m_pc);
        chk("valids", {bus.valid_id, bus.valid_ex, bus.valid_mem, bus.valid_wb}, {m_vid, m_vex, m_vmem, m_vwb});
        chk("enables", {bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en}, e_en);
        chk("flushes", {bus.ifid_flush, bus.idex_flush}, e_fl);
        chk("fwd_a", bus.fwd_a, exp_fwd(bus.ex_rs1_addr));
        chk("fwd_b", bus.fwd_b, exp_fwd(bus.ex_rs2_addr));
        chk("cycle_cnt", bus.cycle_cnt, m_cyc);
        chk("stall_cnt", bus.stall_cnt, m_stl);
        chk("flush_cnt", bus.flush_cnt, m_fl);
        @(posedge clk);
        #1;
        m_boot = 1'b0;
        m_pc = n_pc; m_vid = n_id; m_vex = n_ex; m_vmem = n_mem; m_vwb = n_wb;
        m_cyc = n_cyc; m_stl = n_stl; m_fl = n_fl;
    endtask

    initial begin
        // 1: reset held 3 clocks, then BOOT, then fetch from 0 upward
        set_idle();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_valids", {bus.valid_id, bus.valid_ex, bus.valid_mem, bus.valid_wb}, 4'b0000);
        chk("rst_en", {bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en}, 4'b0000);
        chk("rst_cnt", bus.cycle_cnt, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();
        for (int i = 1; i <= 6; i++) begin
            chk("boot_pc_seq", bus.pc, 32'((i - 1) * 4));
            chk("boot_valid_wb", bus.valid_wb, (i >= 5) ? 1'b1 : 1'b0);
            cyc();
        end

        // 2: lw x5 in EX, add x6,x5,x1 in ID -> one bubble, PC held, then WB forward
        bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd_addr = 5'd5;
        bus.id_rs1_used = 1'b1; bus.id_rs1_addr = 5'd5; bus.id_rs2_used = 1'b1; bus.id_rs2_addr = 5'd1;
        #1;
        chk("lu_idex_flush", bus.idex_flush, 1'b1);
        chk("lu_ifid_en", bus.ifid_en, 1'b0);
        held_pc = bus.pc;
        s0 = m_stl;
        cyc();
        chk("lu_pc_hold", bus.pc, held_pc);
        chk("lu_stall_cnt", bus.stall_cnt, s0 + 1);
        set_idle();
        cyc();
        bus.ex_rs1_addr = 5'd5; bus.wb_rd_addr = 5'd5; bus.wb_reg_write = 1'b1;
        #1;
        chk("lu_fwd_a_wb", bus.fwd_a, 2'b10);
        cyc();

        // 3: add x3 in MEM, sub x4,x3,x3 in EX -> both from EX/MEM; x0 producer never forwards
        set_idle();
        bus.mem_reg_write = 1'b1; bus.mem_rd_addr = 5'd3; bus.ex_rs1_addr = 5'd3; bus.ex_rs2_addr = 5'd3;
        bus.wb_reg_write = 1'b1; bus.wb_rd_addr = 5'd3;
        #1;
        chk("fwd_mem_a", bus.fwd_a, 2'b01);
        chk("fwd_mem_b", bus.fwd_b, 2'b01);
        bus.mem_rd_addr = 5'd0; bus.ex_rs1_addr = 5'd0; bus.wb_rd_addr = 5'd0;
        #1;
        chk("fwd_x0", bus.fwd_a, 2'b00);
        cyc();

        // 4: redirect to 0x40
        set_idle();
        bus.ex_redirect = 1'b1; bus.ex_target = 32'h40;
        f0 = m_fl;
        cyc();
        chk("redir_pc", bus.pc, 32'h40);
        chk("redir_valid_id_ex", {bus.valid_id, bus.valid_ex}, 2'b00);
        chk("redir_flush_cnt", bus.flush_cnt, f0 + 1);
        set_idle();
        cyc();
        cyc();

        // 5: redirect and load-use together -> redirect wins, no extra stall
        bus.ex_redirect = 1'b1; bus.ex_target = 32'h80;
        bus.ex_mem_read = 1'b1; bus.ex_rd_addr = 5'd7; bus.id_rs1_used = 1'b1; bus.id_rs1_addr = 5'd7;
        s0 = m_stl;
        cyc();
        chk("rlu_pc", bus.pc, 32'h80);
        chk("rlu_stall_cnt", bus.stall_cnt, s0);
        chk("rlu_valid_id_ex", {bus.valid_id, bus.valid_ex}, 2'b00);
        set_idle();
        cyc();
        chk("rlu_pc_next", bus.pc, 32'h84);
        chk("rlu_valid_id", bus.valid_id, 1'b1);
        cyc();
        cyc();

        // 6: three data-wait cycles freeze everything, then async reset mid-stall
        bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
        held_pc = bus.pc;
        held_v  = {bus.valid_id, bus.valid_ex, bus.valid_mem, bus.valid_wb};
        s0 = m_stl;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("dw_en", {bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en}, 4'b0000);
            cyc();
            chk("dw_pc_hold", bus.pc, held_pc);
            chk("dw_valid_hold", {bus.valid_id, bus.valid_ex, bus.valid_mem, bus.valid_wb}, held_v);
        end
        chk("dw_stall_cnt", bus.stall_cnt, s0 + 3);
        bus.dmem_ready = 1'b1;
        cyc();
        chk("dw_done_stall_cnt", bus.stall_cnt, s0 + 3);
        chk("dw_done_pc", bus.pc, held_pc + 4);
        bus.dmem_ready = 1'b0;
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_pc", bus.pc, 32'h0);
        chk("mid_rst_valids", {bus.valid_id, bus.valid_ex, bus.valid_mem, bus.valid_wb}, 4'b0000);
        chk("mid_rst_en", {bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en}, 4'b0000);
        chk("mid_rst_cnts", {bus.cycle_cnt, bus.stall_cnt}, 64'h0);
        chk("mid_rst_flush_cnt", bus.flush_cnt, 32'h0);
        model_reset();
        set_idle();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            bus.imem_ready    = ($urandom_range(0, 4) != 0);
            bus.dmem_req      = 1'($urandom_range(0, 1));
            bus.dmem_ready    = ($urandom_range(0, 3) != 0);
            bus.id_rs1_addr   = RA_W'($urandom_range(0, 3));
            bus.id_rs1_used   = 1'($urandom_range(0, 1));
            bus.id_rs2_addr   = RA_W'($urandom_range(0, 3));
            bus.id_rs2_used   = 1'($urandom_range(0, 1));
            bus.ex_rs1_addr   = RA_W'($urandom_range(0, 3));
            bus.ex_rs2_addr   = RA_W'($urandom_range(0, 3));
            bus.ex_rd_addr    = RA_W'($urandom_range(0, 3));
            bus.ex_reg_write  = 1'($urandom_range(0, 1));
            bus.ex_mem_read   = 1'($urandom_range(0, 1));
            bus.mem_rd_addr   = RA_W'($urandom_range(0, 3));
            bus.mem_reg_write = 1'($urandom_range(0, 1));
            bus.wb_rd_addr    = RA_W'($urandom_range(0, 3));
            bus.wb_reg_write  = 1'($urandom_range(0, 1));
            bus.ex_redirect   = ($urandom_range(0, 7) == 0);
            bus.ex_target     = {$urandom_range(0, 32'hFFFF), 2'b00};
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
